regfile_write_arbiter: RTL and testbench

- Shares the single write port of `register_file` (write, addr_in, data_in) between two writeback requesters.
- Requester 0 is the main ALU/load writeback; requester 1 is a slow unit (mul/div).
- Buffers requests in per-requester FIFOs and grants one write per cycle.
- Exports a hazard flag so decode can stall on reads of registers with pending writes.

---
 rtl/regfile_write_arbiter_pkg.sv | 12 +
 rtl/regarb_fifo.sv | 82 ++++++++
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter:
// register address/data widths, the hardwired-zero register, and the grant encoding.
package regfile_write_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    GNT_REQ0 = 1'b0,
    GNT_REQ1 = 1'b1
  } grant_e;
endpackage

// File: rtl/regarb_fifo.sv
// Synchronous {addr, data} FIFO for one writeback requester; exposes the head entry
// plus a per-slot valid/addr view so the parent can check pending-write hazards.
module regarb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [ADDR_W-1:0]       push_addr_i,
  input  logic [DATA_W-1:0]       push_data_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [ADDR_W-1:0]       head_addr_o,
  output logic [DATA_W-1:0]       head_data_o,
  output logic [DEPTH-1:0]        ent_vld_o,
  output logic [DEPTH*ADDR_W-1:0] ent_addr_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  off [DEPTH];
  logic              do_push, do_pop;

  // A full FIFO refuses the push even when it pops in the same cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + PTR_W'(1);
    if (do_pop)  head_d = head_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem_q[tail_q] <= push_addr_i;
      data_mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_addr_o = addr_mem_q[head_q];
  assign head_data_o = data_mem_q[head_q];

  // Slot i is live when its distance from the head is below the occupancy count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i]                         = PTR_W'(i) - head_q;
      ent_vld_o[i]                   = ({1'b0, off[i]} < count_q);
      ent_addr_o[i*ADDR_W +: ADDR_W] = addr_mem_q[i];
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register_file write port between the ALU/load and mul/div writebacks.
// Define REGARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addr_in,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [ADDR_W-1:0] chk_addr_a,
  input  logic [ADDR_W-1:0] chk_addr_b,
  output logic              hazard,
  output logic              idle
);
  logic                    full0, empty0, full1, empty1;
  logic                    push0, push1, pop0, pop1, prefer0;
  logic [ADDR_W-1:0]       head_addr0, head_addr1;
  logic [DATA_W-1:0]       head_data0, head_data1;
  logic [DEPTH-1:0]        vld0, vld1;
  logic [DEPTH*ADDR_W-1:0] ents0, ents1;
  logic                    rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]       rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]       rf_data_q, rf_data_d;
  logic                    hazard_c;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] chk, input logic [ADDR_W-1:0] ent);
    return (chk != ADDR_W'(REG_ZERO)) && (chk == ent);
  endfunction

  assign req0_ready = !full0 && !reset;
  assign req1_ready = !full1 && !reset;
  assign push0      = req0_valid && req0_ready;
  assign push1      = req1_valid && req1_ready;

  regarb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo0 (
    .clk(clk), .reset(reset), .push_i(push0), .pop_i(pop0),
    .push_addr_i(req0_addr), .push_data_i(req0_data),
    .full_o(full0), .empty_o(empty0), .head_addr_o(head_addr0), .head_data_o(head_data0),
    .ent_vld_o(vld0), .ent_addr_o(ents0)
  );

  regarb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo1 (
    .clk(clk), .reset(reset), .push_i(push1), .pop_i(pop1),
    .push_addr_i(req1_addr), .push_data_i(req1_data),
    .full_o(full1), .empty_o(empty1), .head_addr_o(head_addr1), .head_data_o(head_data1),
    .ent_vld_o(vld1), .ent_addr_o(ents1)
  );

`ifdef REGARB_ROUND_ROBIN_EN
  grant_e last_gnt_q, last_gnt_d;

  // Ties go to whichever requester was not granted last; only contested cycles update it.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (!empty0 && !empty1) last_gnt_d = pop1 ? GNT_REQ1 : GNT_REQ0;
  end

  always_ff @(posedge clk) begin
    if (reset) last_gnt_q <= GNT_REQ1;
    else       last_gnt_q <= last_gnt_d;
  end

  assign prefer0 = (last_gnt_q == GNT_REQ1);
`else
  assign prefer0 = 1'b1;
`endif

  // Only entries already stored are eligible, so there is no input-to-output bypass.
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (!empty0 && (empty1 || prefer0)) pop0 = 1'b1;
    else if (!empty1)                   pop1 = 1'b1;
  end

  always_comb begin
    rf_write_d = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    if (pop0) begin
      rf_addr_d  = head_addr0;
      rf_data_d  = head_data0;
      rf_write_d = (head_addr0 != ADDR_W'(REG_ZERO));
    end else if (pop1) begin
      rf_addr_d  = head_addr1;
      rf_data_d  = head_data1;
      rf_write_d = (head_addr1 != ADDR_W'(REG_ZERO));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign rf_write   = rf_write_q;
  assign rf_addr_in = rf_addr_q;
  assign rf_data_in = rf_data_q;

  // A write is pending while it sits in either FIFO or in the output register.
  always_comb begin
    hazard_c = rf_write_q && (addr_hit(chk_addr_a, rf_addr_q) || addr_hit(chk_addr_b, rf_addr_q));
    for (int i = 0; i < DEPTH; i++) begin
      if (vld0[i] && (addr_hit(chk_addr_a, ents0[i*ADDR_W +: ADDR_W]) ||
                      addr_hit(chk_addr_b, ents0[i*ADDR_W +: ADDR_W]))) hazard_c = 1'b1;
      if (vld1[i] && (addr_hit(chk_addr_a, ents1[i*ADDR_W +: ADDR_W]) ||
                      addr_hit(chk_addr_b, ents1[i*ADDR_W +: ADDR_W]))) hazard_c = 1'b1;
    end
  end

  assign hazard = hazard_c;
  assign idle   = empty0 && empty1 && !rf_write_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-requester scoreboard queues, a register_file
// model fed by the write port, and immediate-assertion checks at each step.
module tb_regfile_write_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          rf_write;
  logic [AW-1:0] rf_addr_in;
  logic [DW-1:0] rf_data_in;
  logic [AW-1:0] chk_addr_a, chk_addr_b;
  logic          hazard, idle;

  int            n_vec = 0;
  int            n_err = 0;
  wr_t           q0[$];
  wr_t           q1[$];
  int            owner [32];
  logic [DW-1:0] rfm [32];

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_write(rf_write), .rf_addr_in(rf_addr_in), .rf_data_in(rf_data_in),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .hazard(hazard), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    owner[a] = who;
    if (who == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic drive0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v;
    req0_addr  = a;
    req0_data  = d;
  endtask

  task automatic drive1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v;
    req1_addr  = a;
    req1_data  = d;
  endtask

  // register_file model: commits on the edge that ends a cycle with write high.
  always @(posedge clk) begin
    if (rf_write === 1'b1 && rf_addr_in != '0) rfm[rf_addr_in] <= rf_data_in;
  end

  // Every write seen on the port must be the next expected entry of its requester.
  always @(posedge clk) begin : mon
    wr_t e;
    int  sz;
    #1;
    if (rf_write === 1'b1) begin
      sz = (owner[rf_addr_in] == 0) ? q0.size() : q1.size();
      n_vec++;
      assert (sz > 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed addr %0d data 0x%0h, expected no write", rf_addr_in, rf_data_in);
      end
      if (sz > 0) begin
        e = (owner[rf_addr_in] == 0) ? q0.pop_front() : q1.pop_front();
        chk("wr_addr", 32'(rf_addr_in), 32'(e.a));
        chk("wr_data", rf_data_in, e.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rfm[i]   = '0;
      owner[i] = 0;
    end
    reset = 1'b1;
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    chk_addr_a = '0;
    chk_addr_b = '0;

    // Reset state
    step();
    step();
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr_in), 32'd0);
    chk("rst_rf_data", rf_data_in, 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(req1_ready), 32'd1);

    // Single write: accept at edge 1, port at edge 2, register_file at edge 3
    drive0(1'b1, 5'd1, 32'h14);
    exp_wr(0, 5'd1, 32'h14);
    chk_addr_a = 5'd1;
    step();
    drive0(1'b0, '0, '0);
    chk("single_haz_e1", 32'(hazard), 32'd1);
    chk("single_nobypass", 32'(rf_write), 32'd0);
    chk("single_idle_e1", 32'(idle), 32'd0);
    step();
    chk("single_write_e2", 32'(rf_write), 32'd1);
    chk("single_addr_e2", 32'(rf_addr_in), 32'd1);
    chk("single_data_e2", rf_data_in, 32'h14);
    chk("single_haz_e2", 32'(hazard), 32'd1);
    step();
    chk("single_haz_e3", 32'(hazard), 32'd0);
    chk("single_reg1", rfm[1], 32'h14);
    chk("single_idle_e3", 32'(idle), 32'd1);
    chk_addr_a = '0;

    // Tie: requester 0 goes first out of reset in both builds
    drive0(1'b1, 5'd6, 32'h32);
    drive1(1'b1, 5'd9, 32'h28);
    exp_wr(0, 5'd6, 32'h32);
    exp_wr(1, 5'd9, 32'h28);
    chk_addr_b = 5'd9;
    step();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    chk("tie_nowrite", 32'(rf_write), 32'd0);
    chk("tie_haz_queued", 32'(hazard), 32'd1);
    step();
    chk("tie_first_addr", 32'(rf_addr_in), 32'd6);
    chk("tie_haz_mid", 32'(hazard), 32'd1);
    step();
    chk("tie_second_write", 32'(rf_write), 32'd1);
    chk("tie_second_addr", 32'(rf_addr_in), 32'd9);
    step();
    chk("tie_idle", 32'(idle), 32'd1);
    chk("tie_haz_done", 32'(hazard), 32'd0);
    chk_addr_b = '0;

    // Zero register: popped but never written, never hazards
    drive0(1'b1, 5'd0, 32'hDEADBEEF);
    step();
    drive0(1'b0, '0, '0);
    chk("zero_queued_busy", 32'(idle), 32'd0);
    chk("zero_haz_q", 32'(hazard), 32'd0);
    step();
    chk("zero_suppressed", 32'(rf_write), 32'd0);
    chk("zero_popped_data", rf_data_in, 32'hDEADBEEF);
    chk("zero_haz_out", 32'(hazard), 32'd0);
    chk("zero_idle", 32'(idle), 32'd1);
    step();
    chk("zero_reg0", rfm[0], 32'd0);

    // Full: requester 1 fills while requester 0 keeps winning
    drive0(1'b1, 5'd2, 32'hA2);
    drive1(1'b1, 5'd16, 32'hB0);
    exp_wr(0, 5'd2, 32'hA2);
    exp_wr(1, 5'd16, 32'hB0);
    step();
    chk("full_ready1_e1", 32'(req1_ready), 32'd1);
    drive0(1'b1, 5'd3, 32'hA3);
    drive1(1'b1, 5'd17, 32'hB1);
    exp_wr(0, 5'd3, 32'hA3);
    exp_wr(1, 5'd17, 32'hB1);
    step();
    chk("full_ready1_e2", 32'(req1_ready), 32'd0);
    chk("full_ready0_e2", 32'(req0_ready), 32'd1);
    chk("full_addr_e2", 32'(rf_addr_in), 32'd2);
    drive0(1'b1, 5'd4, 32'hA4);
    drive1(1'b1, 5'd18, 32'hB2);
    exp_wr(0, 5'd4, 32'hA4);
    step();
    chk("full_ready1_e3", 32'(req1_ready), 32'd0);
    chk("full_addr_e3", 32'(rf_addr_in), 32'd3);
    drive0(1'b1, 5'd5, 32'hA5);
    drive1(1'b1, 5'd19, 32'hB3);
    exp_wr(0, 5'd5, 32'hA5);
    step();
    chk("full_ready1_e4", 32'(req1_ready), 32'd0);
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    step();
    chk("full_addr_e5", 32'(rf_addr_in), 32'd5);
    step();
    chk("full_drain_b0", 32'(rf_addr_in), 32'd16);
    chk("full_ready1_e6", 32'(req1_ready), 32'd1);
    step();
    chk("full_drain_b1", 32'(rf_addr_in), 32'd17);
    step();
    chk("full_idle", 32'(idle), 32'd1);

    // Reset mid-operation discards everything still queued
    drive0(1'b1, 5'd7, 32'h70);
    drive1(1'b1, 5'd20, 32'h200);
    exp_wr(0, 5'd7, 32'h70);
    owner[20] = 1;
    step();
    drive0(1'b1, 5'd8, 32'h80);
    drive1(1'b1, 5'd21, 32'h210);
    owner[21] = 1;
    step();
    chk("midrst_popped", 32'(rf_addr_in), 32'd7);
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    chk_addr_a = 5'd8;
    chk_addr_b = 5'd21;
    reset = 1'b1;
    #1;
    chk("midrst_haz_before", 32'(hazard), 32'd1);
    chk("midrst_ready0_low", 32'(req0_ready), 32'd0);
    chk("midrst_ready1_low", 32'(req1_ready), 32'd0);
    step();
    reset = 1'b0;
    chk("midrst_write", 32'(rf_write), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_haz", 32'(hazard), 32'd0);
    chk("midrst_addr", 32'(rf_addr_in), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("midrst_idle_later", 32'(idle), 32'd1);
    chk("midrst_reg8", rfm[8], 32'd0);
    chk("midrst_reg21", rfm[21], 32'd0);
    chk("midrst_reg20", rfm[20], 32'd0);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
